// File: rtl/dt_pkg.sv
// Shared image constants and sequencing state type for the distance-transform blocks.
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int WORD_BITS = 16;
  localparam int PIX_AW    = 14;
  localparam int WORD_AW   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } dt_state_e;

endpackage

// File: rtl/dt_pack_shreg.sv
// MSB-first 16-bit packer: shifts one bit per enabled cycle into the LSB and
// presents the completed word, with a one-cycle valid, the cycle after the
// 16th bit arrives. The output word holds until the next word completes.
module dt_pack_shreg
  import dt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_vld
);

  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [3:0]           fill_q, fill_d;
  logic                 vld_q, vld_d;

  // Shift, count fill and latch the word on the 16th bit.
  always_comb begin
    sh_d   = sh_q;
    word_d = word_q;
    fill_d = fill_q;
    vld_d  = 1'b0;
    if (clr) begin
      fill_d = 4'd0;
    end else if (en) begin
      sh_d   = {sh_q[WORD_BITS-2:0], bit_in};
      fill_d = fill_q + 4'd1;
      if (fill_q == 4'd15) begin
        word_d = sh_d;
        vld_d  = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q   <= '0;
      word_q <= '0;
      fill_q <= 4'd0;
      vld_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      word_q <= word_d;
      fill_q <= fill_d;
      vld_q  <= vld_d;
    end
  end

  assign word     = word_q;
  assign word_vld = vld_q;

endmodule

// File: rtl/dt_bitpack.sv
// Streams the distance map out of the result RAM, thresholds each pixel and
// writes the packed bit-plane image.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing pixel reads 0..16383
// FLUSH  | reads done, draining the last pixel and last word write
// DONE   | one-cycle completion pulse
module dt_bitpack
  import dt_pkg::*;
#(
  parameter int PIX_AW  = 14,
  parameter int WORD_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         thr,
  output logic               busy,
  output logic               done,
  output logic               res_rd,
  output logic [PIX_AW-1:0]  res_addr,
  input  logic [7:0]         res_di,
  output logic               pk_wr,
  output logic [WORD_AW-1:0] pk_addr,
  output logic [15:0]        pk_do,
  output logic [14:0]        pk_cnt
);

  localparam logic [PIX_AW-1:0] PIX_LAST = '1;

  dt_state_e          state_q, state_d;
  logic [7:0]         thr_q, thr_d;
  logic               res_rd_q, res_rd_d;
  logic [PIX_AW-1:0]  res_addr_q, res_addr_d;
  logic               vld_q, vld_d;
  logic [WORD_AW-1:0] pk_addr_q, pk_addr_d;
  logic [14:0]        pk_cnt_q, pk_cnt_d;
  logic               clr;
  logic               pix_bit;
  logic               word_vld;
  logic [15:0]        word;

  assign pix_bit = (res_di >= thr_q);

  // Sequencing, read issue, one-bit counting and packed address advance.
  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    res_rd_d   = res_rd_q;
    res_addr_d = res_addr_q;
    vld_d      = res_rd_q;
    pk_addr_d  = pk_addr_q;
    pk_cnt_d   = pk_cnt_q;
    clr        = 1'b0;

    if (vld_q && pix_bit) pk_cnt_d = pk_cnt_q + 15'd1;
    if (word_vld)         pk_addr_d = pk_addr_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_d      = thr;
          pk_cnt_d   = 15'd0;
          res_addr_d = '0;
          res_rd_d   = 1'b1;
          clr        = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (res_addr_q == PIX_LAST) begin
          res_rd_d = 1'b0;
          state_d  = FLUSH;
        end else begin
          res_addr_d = res_addr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (word_vld && !vld_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      thr_q      <= 8'd0;
      res_rd_q   <= 1'b0;
      res_addr_q <= '0;
      vld_q      <= 1'b0;
      pk_addr_q  <= '0;
      pk_cnt_q   <= 15'd0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      res_rd_q   <= res_rd_d;
      res_addr_q <= res_addr_d;
      vld_q      <= vld_d;
      pk_addr_q  <= pk_addr_d;
      pk_cnt_q   <= pk_cnt_d;
    end
  end

  dt_pack_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (vld_q),
    .bit_in   (pix_bit),
    .word     (word),
    .word_vld (word_vld)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign pk_wr    = word_vld;
  assign pk_addr  = pk_addr_q;
  assign pk_do    = word;
  assign pk_cnt   = pk_cnt_q;

endmodule

// File: tb/tb_dt_bitpack.sv
// Bench for dt_bitpack: result-RAM model, packed-RAM capture and a per-pixel
// reference for the packed image and one-bit count.
module tb_dt_bitpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  thr = 8'd0;
  logic        busy, done, res_rd, pk_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic [9:0]  pk_addr;
  logic [15:0] pk_do;
  logic [14:0] pk_cnt;

  logic [7:0]  mem    [16384];
  logic [15:0] pk     [1024];
  int          pk_tag [1024];
  int          run_id = 0;
  int          wr_cnt = 0;
  int          b2b_cnt = 0;
  logic        prev_wr = 1'b0;
  int          tests = 0;
  int          errs = 0;

  dt_bitpack dut (
    .clk(clk), .rst(rst), .start(start), .thr(thr), .busy(busy), .done(done),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di), .pk_wr(pk_wr),
    .pk_addr(pk_addr), .pk_do(pk_do), .pk_cnt(pk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (res_rd) res_di <= mem[res_addr];

  always @(posedge clk) begin
    prev_wr <= pk_wr;
    if (pk_wr) begin
      pk[pk_addr]     <= pk_do;
      pk_tag[pk_addr] <= run_id;
      wr_cnt          <= wr_cnt + 1;
      if (prev_wr) b2b_cnt <= b2b_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word k covers pixels 16k..16k+15; the first of them lands in bit 15.
  function automatic logic [15:0] exp_word(input int k, input logic [7:0] t);
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[15-j] = (mem[k*16+j] >= t);
    return w;
  endfunction

  function automatic int exp_cnt(input int npix, input logic [7:0] t);
    int n = 0;
    for (int a = 0; a < npix; a++) if (mem[a] >= t) n++;
    return n;
  endfunction

  task automatic reset_check(input string tag);
    check({tag, "_outs"}, {busy, done, res_rd, pk_wr}, 0);
    check({tag, "_addr"}, {res_addr, pk_addr}, 0);
    check({tag, "_data"}, {pk_do, pk_cnt}, 0);
  endtask

  // One run; abort_at != 0 asserts reset in that cycle instead of finishing.
  task automatic run(input string name, input logic [7:0] t, input bit extra, input int abort_at);
    int rel, done_rel, first_wr, dones, base, b2b_base, nw;
    run_id++;
    base = wr_cnt;
    b2b_base = b2b_cnt;
    done_rel = 0;
    first_wr = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    thr = t;
    @(negedge clk);
    start = 1'b0;
    rel = 1;
    check({name, "_c1"}, {busy, res_rd, 18'(res_addr)}, {1'b1, 1'b1, 18'd0});
    while (rel < 16400) begin
      if (abort_at != 0 && rel == abort_at) break;
      if (done) begin
        dones++;
        if (done_rel == 0) done_rel = rel;
      end
      if (pk_wr && first_wr == 0) first_wr = rel;
      if (rel == 16385) check({name, "_rd_fall"}, res_rd, 0);
      if (rel == 16388) check({name, "_busy_fall"}, busy, 0);
      thr = 8'($urandom);
      start = extra && (rel == 100 || rel == 16386);
      @(negedge clk);
      rel++;
    end
    start = 1'b0;
    if (abort_at != 0) begin
      nw = (abort_at - 19) / 16 + 1;
      check({name, "_part_cnt"}, pk_cnt, exp_cnt(abort_at - 2, t));
      for (int k = 0; k < nw; k++) begin
        check({name, "_part_word"}, pk[k], exp_word(k, t));
        check({name, "_part_tag"}, pk_tag[k], run_id);
      end
      rst = 1'b0;
      #1;
      reset_check({name, "_inrst"});
      @(negedge clk);
      reset_check({name, "_inrst2"});
      rst = 1'b1;
      @(negedge clk);
    end else begin
      check({name, "_done_cyc"}, done_rel, 16387);
      check({name, "_done_cnt"}, dones, 1);
      check({name, "_first_wr"}, first_wr, 18);
      check({name, "_writes"}, wr_cnt - base, 1024);
      check({name, "_b2b"}, b2b_cnt - b2b_base, 0);
      check({name, "_pk_cnt"}, pk_cnt, exp_cnt(16384, t));
      for (int k = 0; k < 1024; k++) begin
        check({name, "_word"}, pk[k], exp_word(k, t));
        check({name, "_tag"}, pk_tag[k], run_id);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      pk[k] = 16'h0;
      pk_tag[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset_check("por");
    rst = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
    run("zero", 8'd1, 1'b1, 0);
    check("zero_cnt_abs", pk_cnt, 0);

    mem[5*128+17] = 8'd1;
    run("single", 8'd1, 1'b0, 0);
    check("single_w41", pk[41], 16'h4000);
    check("single_cnt", pk_cnt, 1);

    for (int a = 0; a < 16384; a++) mem[a] = 8'(a % 128);
    run("col64", 8'd64, 1'b0, 0);
    check("col64_w0", pk[0], 16'h0000);
    check("col64_w4", pk[4], 16'hFFFF);
    check("col64_cnt", pk_cnt, 8192);

    run("col0_rst", 8'd0, 1'b0, 5000);

    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    run("rand", 8'($urandom_range(1, 255)), 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
